// File: rtl/apogeo_pkg.sv
// rtl/apogeo_pkg.sv - shared types and counter helpers for the gshare predictor
package apogeo_pkg;

    localparam logic [1:0] CTR_ENC_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_ENC_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_ENC_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_ENC_STRONG_T  = 2'b11;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = CTR_ENC_STRONG_NT,
        CTR_WEAK_NT   = CTR_ENC_WEAK_NT,
        CTR_WEAK_T    = CTR_ENC_WEAK_T,
        CTR_STRONG_T  = CTR_ENC_STRONG_T
    } ctr_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Saturating step of a 2-bit counter toward taken or not-taken.
    function automatic ctr_e ctr_step(ctr_e cur, logic taken);
        logic [1:0] raw;
        raw = cur;
        if (taken && (raw != CTR_ENC_STRONG_T)) begin
            raw = raw + 2'd1;
        end else if (!taken && (raw != CTR_ENC_STRONG_NT)) begin
            raw = raw - 2'd1;
        end
        return ctr_e'(raw);
    endfunction

endpackage

// File: rtl/pattern_history_table.sv
// rtl/pattern_history_table.sv - 2-bit counter array, one sync read port, one sync write port, read-first
module pattern_history_table
    import apogeo_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output ctr_e                     rd_data_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  ctr_e                     wr_data_i
);

    ctr_e mem_q [DEPTH];
    ctr_e rd_data_q;

    // Read sees the array before this cycle's write lands (read-first).
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with init sweep and 2-stage training
module gshare_predictor
    import apogeo_pkg::*;
#(
    parameter int TABLE_SIZE = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_i,
    input  logic [31:0] program_counter_i,
    input  logic        btb_hit_i,
    input  logic        btb_predict_i,
    input  logic [31:0] btb_target_i,
    input  logic        resolve_i,
    input  logic [31:0] resolve_address_i,
    input  logic        resolve_branch_i,
    input  logic        resolve_taken_i,
    input  logic        mispredict_i,
    output logic        ready_o,
    output logic        prediction_valid_o,
    output logic        predict_taken_o,
    output logic [31:0] predict_target_o
);

    localparam int INDEX_BITS = $clog2(TABLE_SIZE);
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(TABLE_SIZE - 1);

    state_e                  state_q;
    logic [INDEX_BITS-1:0]   sweep_q;
    logic                    ready_q;

    logic [INDEX_BITS-1:0]   spec_ghr_q, spec_ghr_d;
    logic [INDEX_BITS-1:0]   arch_ghr_q, arch_ghr_d;
    logic                    fetch_pend_q;

    logic                    upd_valid_q;
    logic                    upd_taken_q;
    logic [INDEX_BITS-1:0]   upd_idx_q;
    logic                    fwd_valid_q;
    logic [INDEX_BITS-1:0]   fwd_idx_q;
    ctr_e                    fwd_data_q;

    logic                    run;
    logic                    flush;
    logic                    resolve_cond;
    logic [INDEX_BITS-1:0]   lookup_idx;
    logic [INDEX_BITS-1:0]   update_idx;
    ctr_e                    lookup_ctr;
    ctr_e                    upd_rd_ctr;
    ctr_e                    upd_base;
    ctr_e                    upd_new;
    logic                    pred_valid;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic                    wr_en;
    logic [INDEX_BITS-1:0]   wr_addr;
    ctr_e                    wr_data;

    logic                    unused_bits;

    assign run          = (state_q == ST_RUN);
    assign flush        = run & resolve_i & mispredict_i;
    assign resolve_cond = run & resolve_i & resolve_branch_i;
    assign lookup_idx   = program_counter_i[INDEX_BITS:1] ^ spec_ghr_q;
    assign update_idx   = resolve_address_i[INDEX_BITS:1] ^ arch_ghr_q;

    // Init sweep: one entry per cycle, then park in RUN without wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            if (sweep_q == LAST_INDEX) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end else begin
                sweep_q <= sweep_q + INDEX_BITS'(1);
            end
        end
    end

    // Prediction outputs line up with the BTB response one cycle after fetch.
    always_comb begin
        pred_valid  = fetch_pend_q & btb_hit_i & ~flush;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (pred_valid) begin
            pred_taken  = btb_predict_i ? lookup_ctr[1] : 1'b1;
            pred_target = btb_target_i;
        end
    end

    // History next-state: a flush restores the committed history, which beats speculation.
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        if (resolve_cond) begin
            arch_ghr_d = {arch_ghr_q[INDEX_BITS-2:0], resolve_taken_i};
        end
        spec_ghr_d = spec_ghr_q;
        if (flush) begin
            spec_ghr_d = arch_ghr_d;
        end else if (pred_valid && btb_predict_i) begin
            spec_ghr_d = {spec_ghr_q[INDEX_BITS-2:0], pred_taken};
        end
    end

    // Training stage 2: take the counter from the write just issued if it hit the same entry.
    always_comb begin
        upd_base = upd_rd_ctr;
        if (fwd_valid_q && (fwd_idx_q == upd_idx_q)) begin
            upd_base = fwd_data_q;
        end
        upd_new = ctr_step(upd_base, upd_taken_q);
    end

    // Single write port shared between the init sweep and training.
    always_comb begin
        wr_en   = upd_valid_q;
        wr_addr = upd_idx_q;
        wr_data = upd_new;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = sweep_q;
            wr_data = CTR_WEAK_NT;
        end
    end

    // Histories, pending-fetch flag and the training pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_ghr_q   <= '0;
            arch_ghr_q   <= '0;
            fetch_pend_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_idx_q    <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_idx_q    <= '0;
            fwd_data_q   <= CTR_STRONG_NT;
        end else begin
            spec_ghr_q   <= spec_ghr_d;
            arch_ghr_q   <= arch_ghr_d;
            fetch_pend_q <= run & fetch_i & ~flush;
            upd_valid_q  <= resolve_cond;
            upd_taken_q  <= resolve_taken_i;
            upd_idx_q    <= update_idx;
            fwd_valid_q  <= upd_valid_q;
            fwd_idx_q    <= upd_idx_q;
            fwd_data_q   <= upd_new;
        end
    end

    // Two identical copies so lookup and training each get a private read port.
    pattern_history_table #(.DEPTH(TABLE_SIZE)) u_pht_lookup (
        .clk_i     (clk_i),
        .rd_addr_i (lookup_idx),
        .rd_data_o (lookup_ctr),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    pattern_history_table #(.DEPTH(TABLE_SIZE)) u_pht_update (
        .clk_i     (clk_i),
        .rd_addr_i (update_idx),
        .rd_data_o (upd_rd_ctr),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    assign unused_bits = ^{program_counter_i[31:INDEX_BITS+1], program_counter_i[0],
                           resolve_address_i[31:INDEX_BITS+1], resolve_address_i[0],
                           lookup_ctr[0]};

    assign ready_o            = ready_q;
    assign prediction_valid_o = pred_valid;
    assign predict_taken_o    = pred_taken;
    assign predict_target_o   = pred_target;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - randomized self-checking bench for gshare_predictor
module tb_gshare_predictor;

    localparam int TS   = 1024;
    localparam int MASK = TS - 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_i;
    logic [31:0] program_counter_i;
    logic        btb_hit_i;
    logic        btb_predict_i;
    logic [31:0] btb_target_i;
    logic        resolve_i;
    logic [31:0] resolve_address_i;
    logic        resolve_branch_i;
    logic        resolve_taken_i;
    logic        mispredict_i;
    logic        ready_o;
    logic        prediction_valid_o;
    logic        predict_taken_o;
    logic [31:0] predict_target_o;

    always #5 clk_i = ~clk_i;

    gshare_predictor #(.TABLE_SIZE(TS)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .fetch_i            (fetch_i),
        .program_counter_i  (program_counter_i),
        .btb_hit_i          (btb_hit_i),
        .btb_predict_i      (btb_predict_i),
        .btb_target_i       (btb_target_i),
        .resolve_i          (resolve_i),
        .resolve_address_i  (resolve_address_i),
        .resolve_branch_i   (resolve_branch_i),
        .resolve_taken_i    (resolve_taken_i),
        .mispredict_i       (mispredict_i),
        .ready_o            (ready_o),
        .prediction_valid_o (prediction_valid_o),
        .predict_taken_o    (predict_taken_o),
        .predict_target_o   (predict_target_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: counters as plain ints, histories as ints modulo TS.
    int      m_pht [TS];
    int      m_vis [TS];
    int      m_spec, m_arch, m_count, m_pend_ctr;
    bit      m_ready, m_pend;
    longint  m_cyc = 0;
    int      q_idx [$];
    int      q_val [$];
    longint  q_due [$];
    bit          exp_valid, exp_taken;
    logic [31:0] exp_target;

    function automatic int pc_index(logic [31:0] a);
        return int'((a >> 1) & 32'(MASK));
    endfunction

    function automatic int fresh_index(int avoid);
        int s;
        s = int'($urandom_range(0, MASK));
        for (int k = 0; k < TS; k++) begin
            int i;
            i = (s + k) & MASK;
            if (i != avoid && m_pht[i] == 1 && m_vis[i] == 1) return i;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0; m_count = 0; m_spec = 0; m_arch = 0;
        m_pend = 1'b0; m_pend_ctr = 0;
        for (int i = 0; i < TS; i++) begin
            m_pht[i] = 1;
            m_vis[i] = 1;
        end
        q_idx.delete(); q_val.delete(); q_due.delete();
    endtask

    task automatic idle_inputs();
        fetch_i = 1'b0; program_counter_i = '0; btb_hit_i = 1'b0; btb_predict_i = 1'b0;
        btb_target_i = '0; resolve_i = 1'b0; resolve_address_i = '0; resolve_branch_i = 1'b0;
        resolve_taken_i = 1'b0; mispredict_i = 1'b0;
    endtask

    task automatic settle();
        bit flush;
        #2;
        flush      = m_ready && resolve_i && mispredict_i;
        exp_valid  = m_pend && btb_hit_i && !flush;
        exp_taken  = exp_valid && (btb_predict_i ? (m_pend_ctr >= 2) : 1'b1);
        exp_target = exp_valid ? btb_target_i : 32'h0;
    endtask

    task automatic advance();
        bit flush;
        bit next_pend;
        int idx, nv, arch_new, lidx;
        flush = m_ready && resolve_i && mispredict_i;
        if (m_ready) begin
            arch_new = m_arch;
            if (resolve_i && resolve_branch_i) begin
                idx = pc_index(resolve_address_i) ^ m_arch;
                if (resolve_taken_i) nv = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
                else                 nv = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
                m_pht[idx] = nv;
                q_idx.push_back(idx); q_val.push_back(nv); q_due.push_back(m_cyc + 1);
                arch_new = ((m_arch << 1) | int'(resolve_taken_i)) & MASK;
            end
            lidx      = pc_index(program_counter_i) ^ m_spec;
            next_pend = fetch_i && !flush;
            if (flush) m_spec = arch_new;
            else if (exp_valid && btb_predict_i) m_spec = ((m_spec << 1) | int'(exp_taken)) & MASK;
            m_arch     = arch_new;
            m_pend     = next_pend;
            m_pend_ctr = m_vis[lidx];
        end else begin
            m_count++;
            if (m_count == TS) m_ready = 1'b1;
        end
        while (q_due.size() > 0 && q_due[0] <= m_cyc) begin
            m_vis[q_idx[0]] = q_val[0];
            void'(q_idx.pop_front()); void'(q_val.pop_front()); void'(q_due.pop_front());
        end
        m_cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic count_init(output int cnt, output int bad);
        cnt = 0; bad = 0;
        while (ready_o !== 1'b1 && cnt < 2000) begin
            fetch_i = 1'($urandom); program_counter_i = $urandom; btb_hit_i = 1'b1;
            btb_predict_i = 1'($urandom); btb_target_i = $urandom; resolve_i = 1'($urandom);
            resolve_address_i = $urandom; resolve_branch_i = 1'b1; resolve_taken_i = 1'($urandom);
            mispredict_i = 1'($urandom);
            settle();
            if (prediction_valid_o !== 1'b0 || predict_taken_o !== 1'b0 || predict_target_o !== 32'h0) bad++;
            advance();
            cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        int cnt, bad, bad_entries;
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        model_reset();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", ready_o); end
        checks++;
        if ({prediction_valid_o, predict_taken_o} !== 2'b00 || predict_target_o !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got v=%0b t=%0b tgt=%h want 0", prediction_valid_o, predict_taken_o, predict_target_o);
        end
        rst_i = 1'b0;
        count_init(cnt, bad);
        checks++;
        if (cnt !== 1024) begin errors++; $display("FAIL init_cycles: got %0d want 1024", cnt); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL init_ignores_fetch: got %0d bad cycles want 0", bad); end
        checks++;
        if (ready_o !== m_ready) begin errors++; $display("FAIL init_ready: got %0b want %0b", ready_o, m_ready); end
        bad_entries = 0;
        for (int i = 0; i < TS; i++) begin
            if (int'(dut.u_pht_lookup.mem_q[i]) !== 1 || int'(dut.u_pht_update.mem_q[i]) !== 1) bad_entries++;
        end
        checks++;
        if (bad_entries !== 0) begin errors++; $display("FAIL init_table: got %0d entries not 01 want 0", bad_entries); end
        checks++;
        if (int'(dut.spec_ghr_q) !== 0 || int'(dut.arch_ghr_q) !== 0) begin
            errors++; $display("FAIL init_ghr: got spec=%0d arch=%0d want 0 0", dut.spec_ghr_q, dut.arch_ghr_q);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b1;
            resolve_address_i = 32'((32'h80 ^ m_arch) << 1);
            settle(); advance();
        end
        idle_inputs();
        repeat (2) begin settle(); advance(); end
        checks++;
        if (int'(dut.u_pht_lookup.mem_q[32'h80]) !== 3) begin
            errors++; $display("FAIL sat_counter: got %0d want 3", dut.u_pht_lookup.mem_q[32'h80]);
        end
        fetch_i = 1'b1; program_counter_i = 32'((32'h80 ^ m_spec) << 1);
        settle(); advance();
        fetch_i = 1'b0; btb_hit_i = 1'b1; btb_predict_i = 1'b1; btb_target_i = $urandom;
        settle();
        checks++;
        if (prediction_valid_o !== 1'b1 || predict_taken_o !== 1'b1 || predict_target_o !== exp_target) begin
            errors++; $display("FAIL sat_predict: got v=%0b t=%0b tgt=%h want 1 1 %h", prediction_valid_o, predict_taken_o, predict_target_o, exp_target);
        end
        advance();
        idle_inputs();
        resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b1;
        resolve_address_i = 32'((32'h80 ^ m_arch) << 1);
        settle(); advance();
        idle_inputs();
        repeat (2) begin settle(); advance(); end
        checks++;
        if (int'(dut.u_pht_lookup.mem_q[32'h80]) !== 3) begin
            errors++; $display("FAIL sat_hold: got %0d want 3", dut.u_pht_lookup.mem_q[32'h80]);
        end
    endtask

    task automatic test_forward();
        int x, y;
        x = fresh_index(32'h80);
        for (int k = 0; k < 2; k++) begin
            resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b0;
            resolve_address_i = 32'((x ^ m_arch) << 1);
            settle(); advance();
        end
        idle_inputs();
        repeat (2) begin settle(); advance(); end
        checks++;
        if (int'(dut.u_pht_lookup.mem_q[x]) !== 0) begin
            errors++; $display("FAIL fwd_not_taken: got %0d want 0", dut.u_pht_lookup.mem_q[x]);
        end
        y = fresh_index(x);
        for (int k = 0; k < 2; k++) begin
            resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b1;
            resolve_address_i = 32'((y ^ m_arch) << 1);
            settle(); advance();
        end
        idle_inputs();
        repeat (2) begin settle(); advance(); end
        checks++;
        if (int'(dut.u_pht_update.mem_q[y]) !== 3) begin
            errors++; $display("FAIL fwd_taken: got %0d want 3", dut.u_pht_update.mem_q[y]);
        end
    endtask

    task automatic test_read_first();
        int x;
        x = fresh_index(32'h80);
        resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b1;
        resolve_address_i = 32'((x ^ m_arch) << 1);
        settle(); advance();
        idle_inputs();
        fetch_i = 1'b1; program_counter_i = 32'((x ^ m_spec) << 1);
        settle(); advance();
        fetch_i = 1'b0; btb_hit_i = 1'b1; btb_predict_i = 1'b1; btb_target_i = $urandom;
        settle();
        checks++;
        if (prediction_valid_o !== 1'b1 || predict_taken_o !== 1'b0) begin
            errors++; $display("FAIL read_first_old: got v=%0b t=%0b want 1 0", prediction_valid_o, predict_taken_o);
        end
        advance();
        idle_inputs();
        fetch_i = 1'b1; program_counter_i = 32'((x ^ m_spec) << 1);
        settle(); advance();
        fetch_i = 1'b0; btb_hit_i = 1'b1; btb_predict_i = 1'b1; btb_target_i = $urandom;
        settle();
        checks++;
        if (prediction_valid_o !== 1'b1 || predict_taken_o !== 1'b1) begin
            errors++; $display("FAIL read_first_new: got v=%0b t=%0b want 1 1", prediction_valid_o, predict_taken_o);
        end
        advance();
        idle_inputs();
        settle(); advance();
    endtask

    task automatic test_jump();
        int spec_before;
        spec_before = m_spec;
        fetch_i = 1'b1; program_counter_i = $urandom;
        settle(); advance();
        fetch_i = 1'b0; btb_hit_i = 1'b1; btb_predict_i = 1'b0; btb_target_i = 32'h2000;
        settle();
        checks++;
        if (prediction_valid_o !== 1'b1 || predict_taken_o !== 1'b1 || predict_target_o !== 32'h2000) begin
            errors++; $display("FAIL jump_predict: got v=%0b t=%0b tgt=%h want 1 1 2000", prediction_valid_o, predict_taken_o, predict_target_o);
        end
        advance();
        idle_inputs();
        checks++;
        if (int'(dut.spec_ghr_q) !== spec_before) begin
            errors++; $display("FAIL jump_ghr: got %0d want %0d", dut.spec_ghr_q, spec_before);
        end
        settle();
        checks++;
        if (prediction_valid_o !== 1'b0 || predict_taken_o !== 1'b0 || predict_target_o !== 32'h0) begin
            errors++; $display("FAIL idle_outputs: got v=%0b t=%0b tgt=%h want 0", prediction_valid_o, predict_taken_o, predict_target_o);
        end
        advance();
    endtask

    task automatic test_mispredict();
        int y;
        for (int k = 0; k < 11; k++) begin
            y = int'($urandom_range(0, MASK));
            if (y == 32'h80) y = 32'h81;
            resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = (k == 10);
            resolve_address_i = 32'((y ^ m_arch) << 1);
            settle(); advance();
        end
        idle_inputs();
        repeat (2) begin settle(); advance(); end
        checks++;
        if (int'(dut.arch_ghr_q) !== 1) begin errors++; $display("FAIL arch_ghr_setup: got %0d want 1", dut.arch_ghr_q); end
        for (int k = 0; k < 3; k++) begin
            fetch_i = 1'b1; program_counter_i = 32'((32'h80 ^ m_spec) << 1);
            settle(); advance();
            fetch_i = 1'b0; btb_hit_i = 1'b1; btb_predict_i = 1'b1; btb_target_i = $urandom;
            settle();
            checks++;
            if (prediction_valid_o !== 1'b1 || predict_taken_o !== 1'b1) begin
                errors++; $display("FAIL spec_taken_%0d: got v=%0b t=%0b want 1 1", k, prediction_valid_o, predict_taken_o);
            end
            advance();
            idle_inputs();
        end
        resolve_i = 1'b1; resolve_branch_i = 1'b1; resolve_taken_i = 1'b0; mispredict_i = 1'b1;
        resolve_address_i = $urandom; fetch_i = 1'b1; program_counter_i = $urandom;
        settle(); advance();
        idle_inputs();
        btb_hit_i = 1'b1; btb_predict_i = 1'b1; btb_target_i = $urandom;
        settle();
        checks++;
        if (int'(dut.spec_ghr_q) !== 2) begin errors++; $display("FAIL flush_ghr: got %0d want 2", dut.spec_ghr_q); end
        checks++;
        if (prediction_valid_o !== 1'b0 || predict_taken_o !== 1'b0 || predict_target_o !== 32'h0) begin
            errors++; $display("FAIL flush_suppress: got v=%0b t=%0b tgt=%h want 0", prediction_valid_o, predict_taken_o, predict_target_o);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fetch_i           = 1'($urandom);
            program_counter_i = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) << 1) | 32'($urandom_range(0, 1));
            btb_hit_i         = ($urandom_range(0, 3) != 0);
            btb_predict_i     = ($urandom_range(0, 3) != 0);
            btb_target_i      = $urandom;
            resolve_i         = 1'($urandom);
            resolve_address_i = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) << 1);
            resolve_branch_i  = ($urandom_range(0, 4) != 0);
            resolve_taken_i   = 1'($urandom);
            mispredict_i      = ($urandom_range(0, 6) == 0);
            settle();
            checks++;
            if (prediction_valid_o !== exp_valid || predict_taken_o !== exp_taken || predict_target_o !== exp_target) begin
                errors++;
                $display("FAIL rand_pred c=%0d: got v=%0b t=%0b tgt=%h want %0b %0b %h", c, prediction_valid_o, predict_taken_o, predict_target_o, exp_valid, exp_taken, exp_target);
            end
            checks++;
            if (int'(dut.spec_ghr_q) !== m_spec || int'(dut.arch_ghr_q) !== m_arch) begin
                errors++;
                $display("FAIL rand_ghr c=%0d: got spec=%0d arch=%0d want %0d %0d", c, dut.spec_ghr_q, dut.arch_ghr_q, m_spec, m_arch);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_init();
        int cnt, bad;
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        model_reset();
        rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || int'(dut.spec_ghr_q) !== 0 || int'(dut.arch_ghr_q) !== 0) begin
            errors++; $display("FAIL run_reset: got ready=%0b spec=%0d arch=%0d want 0 0 0", ready_o, dut.spec_ghr_q, dut.arch_ghr_q);
        end
        repeat (500) begin settle(); advance(); end
        rst_i = 1'b1;
        #2;
        model_reset();
        rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_init_ready: got %0b want 0", ready_o); end
        count_init(cnt, bad);
        checks++;
        if (cnt !== 1024) begin errors++; $display("FAIL mid_init_cycles: got %0d want 1024", cnt); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_init_outputs: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_saturate();
        test_forward();
        test_read_first();
        test_jump();
        test_mispredict();
        test_random();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter TABLE_SIZE, default 1024, number of pattern-history-table (PHT) entries; power of 2, at least 4.
REQ-002 SHALL have localparam INDEX_BITS = $clog2(TABLE_SIZE), which is also the global history register (GHR) width.
REQ-003 SHALL have ports clk_i input 1: the single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port fetch_i input 1: program_counter_i is a valid lookup this cycle.
REQ-006 SHALL have port program_counter_i input 32: fetch PC, presented in the same cycle as to the BTB.
REQ-007 SHALL have ports btb_hit_i input 1, btb_predict_i input 1, btb_target_i input 32: BTB outputs, valid one cycle after program_counter_i.
REQ-008 SHALL have ports resolve_i input 1, resolve_address_i input 32, resolve_branch_i input 1, resolve_taken_i input 1: in-order resolution from execute.
REQ-009 SHALL have port mispredict_i input 1: flush; qualified by resolve_i.
REQ-010 SHALL have port ready_o output 1: table initialised, lookups honoured.
REQ-011 SHALL have ports prediction_valid_o output 1, predict_taken_o output 1, predict_target_o output 32: fetch redirect.

Function
REQ-012 PHT SHALL hold 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-013 FSM SHALL have states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-014 INIT SHALL write 01 to one entry per cycle, incrementing the counter; after entry TABLE_SIZE-1, go to RUN (TABLE_SIZE cycles total).
REQ-015 In INIT, ready_o=0 and fetch_i, resolve_i, mispredict_i SHALL be ignored; ready_o=1 in RUN.
REQ-016 Lookup index SHALL be program_counter_i[INDEX_BITS:1] XOR spec_ghr; PHT read is registered, so the result aligns with the BTB outputs.
REQ-017 prediction_valid_o SHALL be 1 exactly one cycle after a RUN-state fetch_i when btb_hit_i=1 and no flush occurred in the intervening cycle.
REQ-018 predict_taken_o SHALL be counter[1] when btb_predict_i=1 (conditional branch), and 1 otherwise (jump).
REQ-019 predict_target_o SHALL be btb_target_i.
REQ-020 Outputs SHALL be 0 whenever prediction_valid_o=0.
REQ-021 On a valid conditional prediction, spec_ghr SHALL become {spec_ghr[INDEX_BITS-2:0], predict_taken_o}; jumps SHALL NOT shift it.
REQ-022 Update index SHALL be resolve_address_i[INDEX_BITS:1] XOR arch_ghr, sampled with arch_ghr before its shift.
REQ-023 Update SHALL act only when resolve_i & resolve_branch_i.
REQ-024 Update SHALL be 2 stages: read, then write of the incremented counter (taken) or decremented counter (not taken), saturating at 11 and 00.
REQ-025 Back-to-back updates to the same index SHALL forward the in-flight written value; no update SHALL be lost.
REQ-026 arch_ghr SHALL shift in resolve_taken_i on every conditional resolution.
REQ-027 On resolve_i & mispredict_i, spec_ghr SHALL load the post-shift arch_ghr next cycle, and any prediction pending that cycle SHALL be suppressed; the flush wins over a simultaneous fetch_i.
REQ-028 A lookup and update write to the same index in the same cycle SHALL return the old value (read-first).
REQ-029 GHR shifts SHALL drop the MSB (modulo 2^INDEX_BITS); the sweep counter SHALL not wrap.

Reset
REQ-030 Asynchronous rst_i SHALL clear state to INIT, the sweep counter, spec_ghr, arch_ghr, the update pipeline, ready_o, prediction_valid_o, predict_taken_o and predict_target_o to 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep at entry 0; PHT contents are not reset directly.

Structure
REQ-032 The counter enum type and the counter encoding constants SHALL reside in apogeo_pkg.
REQ-033 PHT SHALL be sub-module pattern_history_table: one synchronous read port, one synchronous write port, read-first.

Verification
REQ-034 Reset, then count cycles: ready_o rises after exactly 1024 cycles; every entry reads 01.
REQ-035 Three taken resolutions of PC 0x100 with GHR 0, then lookup with BTB hit and predict=1: predict_taken_o=1, counter reaches 11, fourth taken resolution leaves it at 11.
REQ-036 Two consecutive same-index not-taken resolutions starting from 01: final counter is 00 (forwarding checked).
REQ-037 Lookup with btb_hit_i=1, btb_predict_i=0, target 0x2000: predict_taken_o=1, predict_target_o=0x2000, spec_ghr unchanged.
REQ-038 Three speculative taken predictions, then mispredict with arch_ghr=0b01 and resolve_taken_i=0: spec_ghr=0b010 next cycle; the concurrent fetch yields prediction_valid_o=0.
REQ-039 rst_i pulsed at sweep index 500: ready_o stays 0 for 1024 further cycles.
